ntt_coef_ram: RTL and testbench
===============================

# ntt_coef_ram

Coefficient memory that answers the NTT processor's RAM port: one 96-bit word per cycle, eight 12-bit lanes per word. It stores 256 words, reads with one-cycle latency and accepts a write every cycle. A host-side engine loads and unloads polynomials as serial 12-bit coefficient streams with valid/ready handshakes, packing and unpacking them around the core's traffic.

## Interface
Parameters:
- Q, 3329, Kyber modulus used for load-side reduction
- DEPTH, 256, words of storage (address width 8)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- r_data_addr  in  8  core read address, sampled every cycle
- r_data  out  96  core read data; lane k in bits [12k+11:12k]
- w_data_en  in  1  core write strobe
- w_data_addr  in  8  core write address
- w_data  in  96  core write data
- cmd_valid / cmd_ready  in / out  1 / 1  host command handshake
- cmd_op  in  1  0 = LOAD, 1 = UNLOAD
- cmd_base  in  8  first word address
- cmd_words  in  5  word count; 0 means 32 (one full polynomial)
- in_valid / in_ready  in / out  1 / 1  LOAD coefficient stream
- in_coef  in  12  LOAD coefficient
- out_valid / out_ready  out / in  1 / 1  UNLOAD coefficient stream
- out_coef  out  12  UNLOAD coefficient
- host_done  out  1  one-cycle pulse when a command completes

## Operation
- Storage has one read port and one write port. The core always owns both. The host engine uses a port only in cycles the core leaves free: read when never contending (core reads every cycle while active; host read stalls whenever r_data_addr differs from the host address), write only when w_data_en = 0.
- Core read: r_data is the registered content at the address sampled on the previous edge.
- Same-address read and write in one cycle returns the new w_data (write-first bypass).
- Host FSM states:
  - IDLE: cmd_ready = 1. A cmd handshake latches op, base and count, then moves to LOAD or UNLOAD.
  - LOAD: accept coefficients. Coefficient n of a word goes to lane n (n = 0..7). Reduction: values ≥ Q become value − Q; one subtraction suffices because 4095 < 2Q. After lane 7 the packed word becomes pending and in_ready drops. Pending is written at base+i when w_data_en = 0, then in_ready rises again. After the last word is written → DONE.
  - UNLOAD: issue a read of base+i, wait a cycle, capture the word, then present lanes 0..7 in order. A lane advances only on out_valid & out_ready. After lane 7, move to the next word. After the last word → DONE.
  - DONE: host_done = 1 for one cycle → IDLE.
- Addresses wrap mod 256: base 250 with 32 words covers 250..255, then 0..25.
- cmd_valid outside IDLE is ignored; cmd_ready = 0.

## Timing
- Values after reset: r_data = 0, cmd_ready = 1, in_ready = 0, out_valid = 0, out_coef = 0, host_done = 0, FSM = IDLE, storage contents undefined.
- Core read latency is 1 cycle, at full throughput.
- LOAD throughput is 8 coefficients per 8 cycles plus 1 write cycle when uncontended. in_ready rises the cycle after the command is accepted.
- UNLOAD: first out_valid 2 cycles after the cmd handshake when uncontended; 1 bubble cycle between words.
- Core contention stalls host accesses without data loss: a pending word is held, and an unload read is retried.
- rst_n assertion at any point: everything returns to reset values immediately. A partially packed word is discarded.

## Structure
- Package ntt_pkg: Q, COEF_W = 12, LANES = 8, ADDR_W = 8, host state enum, cmd_op encoding.
- Sub-module coef_lane_pack: 8×12 shift/pack register with lane counter and mod-Q reduction. It serves the LOAD side; UNLOAD uses its mirror selector inline.

## Test plan
- Core streaming: write word with lanes {7..0} = {193,192,65,64,129,128,1,0} to address 0, read 0 next cycle → r_data equals it one cycle later. Reads of 0..31 back-to-back → one word per cycle.
- Bypass: write 0x…AB to 5 and read 5 in the same cycle → r_data = new value next cycle.
- LOAD with reduction: base 0, words 1, coefficients 0,1,3328,3329,3330,4095,12,13 → word 0 lanes = 0,1,3328,0,1,766,12,13; host_done pulses once.
- UNLOAD with backpressure: words 0 (meaning 32) from base 250, out_ready toggling 1/0 → 256 coefficients in order, addresses wrap 255→0, host_done after the last.
- Contention: LOAD while w_data_en = 1 every cycle for 20 cycles → in_ready held low after lane 7. No writes from the host until the core drops w_data_en, then the pending word is committed intact.
- Reset mid-UNLOAD after 3 coefficients → out_valid = 0, cmd_ready = 1 immediately; a new command runs normally.

Source files
------------

// File: rtl/ntt_coef_ram_pkg.sv
// -----------------------------------------------------------------------------
// ntt_pkg
// Shared constants, types and helpers for the NTT coefficient memory.
//   Q       : Kyber modulus used to reduce coefficients on the load path
//   COEF_W  : coefficient width (12 bits)
//   LANES   : coefficients packed per storage word (8)
//   ADDR_W  : storage address width (8 bits, 256 words)
//   host_state_e : host-side load/unload engine states
//   cmd_op_e     : host command opcode encoding
// -----------------------------------------------------------------------------
package ntt_pkg;

   localparam int unsigned Q      = 3329;
   localparam int          COEF_W = 12;
   localparam int          LANES  = 8;
   localparam int          ADDR_W = 8;
   localparam int          WORD_W = COEF_W * LANES;

   typedef logic [COEF_W-1:0] coef_t;
   typedef logic [WORD_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [2:0] {
      HS_IDLE,
      HS_LOAD,
      HS_RD,     // waiting for the core to read the host's word address
      HS_CAP,    // r_data holds the host's word this cycle
      HS_OUT,    // presenting lanes of the captured word
      HS_DONE
   } host_state_e;

   typedef enum logic {
      OP_LOAD   = 1'b0,
      OP_UNLOAD = 1'b1
   } cmd_op_e;

   // A single conditional subtraction is a full reduction because the largest
   // 12-bit input (4095) is below 2*Q.
   function automatic coef_t reduce_q(input coef_t v, input coef_t q);
      return (v >= q) ? coef_t'(v - q) : v;
   endfunction

endpackage

// File: rtl/ntt_coef_ram_if.sv
// -----------------------------------------------------------------------------
// ntt_coef_ram_if
// Host-side command and coefficient stream bundle of the coefficient memory.
//   cmd_valid/cmd_ready, cmd_op, cmd_base, cmd_words : command handshake
//   in_valid/in_ready, in_coef                        : LOAD coefficient stream
//   out_valid/out_ready, out_coef                     : UNLOAD coefficient stream
//   host_done                                         : command-complete pulse
// master = host driving commands, slave = the memory.
// -----------------------------------------------------------------------------
interface ntt_coef_ram_if;
   import ntt_pkg::*;

   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_op;
   addr_t      cmd_base;
   logic [4:0] cmd_words;

   logic       in_valid;
   logic       in_ready;
   coef_t      in_coef;

   logic       out_valid;
   logic       out_ready;
   coef_t      out_coef;

   logic       host_done;

   modport master (
      output cmd_valid, cmd_op, cmd_base, cmd_words, in_valid, in_coef, out_ready,
      input  cmd_ready, in_ready, out_valid, out_coef, host_done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_base, cmd_words, in_valid, in_coef, out_ready,
      output cmd_ready, in_ready, out_valid, out_coef, host_done
   );

endinterface

// File: rtl/ntt_coef_ram_pack.sv
// -----------------------------------------------------------------------------
// coef_lane_pack
// Packs a serial coefficient stream into 8x12-bit words, reducing each
// coefficient mod Q as it enters.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart at lane 0 (new command); discards a partial word
//   load_en    : accept coef_in into the current lane
//   coef_in    : incoming coefficient
//   word       : packed word, lane k in bits [12k+11:12k]
//   last       : load_en on lane 7 (word complete after this edge)
// -----------------------------------------------------------------------------
module coef_lane_pack
   import ntt_pkg::*;
#(
   parameter int unsigned Q_MOD = ntt_pkg::Q
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  clr,
   input  logic  load_en,
   input  coef_t coef_in,
   output word_t word,
   output logic  last
);

   localparam coef_t QC = coef_t'(Q_MOD);

   logic [2:0] lane_q;
   word_t      word_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_q <= '0;
         word_q <= '0;
      end else if (clr) begin
         lane_q <= '0;
         word_q <= '0;
      end else if (load_en) begin
         word_q[lane_q*COEF_W +: COEF_W] <= reduce_q(coef_in, QC);
         lane_q                          <= lane_q + 3'd1;
      end
   end

   assign word = word_q;
   assign last = load_en && (lane_q == 3'(LANES - 1));

endmodule

// File: rtl/ntt_coef_ram.sv
// -----------------------------------------------------------------------------
// ntt_coef_ram
// 256 x 96-bit coefficient memory for the NTT core with a host load/unload
// engine that streams 12-bit coefficients in and out around core traffic.
//   clk, rst_n   : clock, async active-low reset
//   r_data_addr  : core read address, sampled every cycle
//   r_data       : registered read data (write-first on same-address write)
//   w_data_en    : core write strobe; core always wins the write port
//   w_data_addr  : core write address
//   w_data       : core write data
//   host         : host command / coefficient stream interface (slave side)
// The host never owns the read address: an unload read completes only in a
// cycle where the core happens to present the host's word address.
// -----------------------------------------------------------------------------
module ntt_coef_ram #(
   parameter int unsigned Q     = ntt_pkg::Q,
   parameter int unsigned DEPTH = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  ntt_pkg::addr_t      r_data_addr,
   output ntt_pkg::word_t      r_data,
   input  logic                w_data_en,
   input  ntt_pkg::addr_t      w_data_addr,
   input  ntt_pkg::word_t      w_data,
   ntt_coef_ram_if.slave       host
);
   import ntt_pkg::*;

   word_t       mem [DEPTH];

   host_state_e state_q, state_d;
   addr_t       host_addr;
   logic [5:0]  words_left;
   logic        pending;
   word_t       out_word;
   logic [2:0]  out_lane;

   word_t       pack_word;
   logic        pack_last;

   logic        cmd_hs, in_hs, host_wr;
   logic        last_word, last_lane;
   logic        wr_en;
   addr_t       wr_addr;
   word_t       wr_data;

   assign cmd_hs    = host.cmd_valid && (state_q == HS_IDLE);
   assign in_hs     = host.in_valid && (state_q == HS_LOAD) && !pending;
   assign host_wr   = (state_q == HS_LOAD) && pending && !w_data_en;
   assign last_word = (words_left == 6'd1);
   assign last_lane = (out_lane == 3'(LANES - 1));

   coef_lane_pack #(.Q_MOD(Q)) u_pack (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (cmd_hs),
      .load_en (in_hs),
      .coef_in (host.in_coef),
      .word    (pack_word),
      .last    (pack_last)
   );

   // ---------------------------------------------------------------- storage
   assign wr_en   = w_data_en || host_wr;
   assign wr_addr = w_data_en ? w_data_addr : host_addr;
   assign wr_data = w_data_en ? w_data : pack_word;

   // NOTE: the array has no reset so it maps onto RAM macros; contents are
   // undefined after reset and only the output register is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else if (wr_en && (wr_addr == r_data_addr)) begin
         r_data <= wr_data;
      end else begin
         r_data <= mem[r_data_addr];
      end
   end

   // ------------------------------------------------------------- host FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HS_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_d        = state_q;
      host.cmd_ready = 1'b0;
      host.in_ready  = 1'b0;
      host.out_valid = 1'b0;
      host.out_coef  = '0;
      host.host_done = 1'b0;
      case (state_q)
         HS_IDLE: begin
            host.cmd_ready = 1'b1;
            if (host.cmd_valid) begin
               state_d = (cmd_op_e'(host.cmd_op) == OP_UNLOAD) ? HS_RD : HS_LOAD;
            end
         end
         HS_LOAD: begin
            host.in_ready = !pending;
            if (host_wr && last_word) begin
               state_d = HS_DONE;
            end
         end
         HS_RD: begin
            if (r_data_addr == host_addr) begin
               state_d = HS_CAP;
            end
         end
         HS_CAP: begin
            state_d = HS_OUT;
         end
         HS_OUT: begin
            host.out_valid = 1'b1;
            host.out_coef  = out_word[out_lane*COEF_W +: COEF_W];
            if (host.out_ready && last_lane) begin
               // The next word's read is issued alongside the final lane when
               // the core already points at it, leaving a single bubble.
               if (last_word) begin
                  state_d = HS_DONE;
               end else if (r_data_addr == addr_t'(host_addr + 8'd1)) begin
                  state_d = HS_CAP;
               end else begin
                  state_d = HS_RD;
               end
            end
         end
         HS_DONE: begin
            host.host_done = 1'b1;
            state_d        = HS_IDLE;
         end
         default: state_d = HS_IDLE;
      endcase
   end

   // --------------------------------------------------------- host datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         host_addr  <= '0;
         words_left <= '0;
         pending    <= 1'b0;
         out_word   <= '0;
         out_lane   <= '0;
      end else begin
         case (state_q)
            HS_IDLE: begin
               if (host.cmd_valid) begin
                  host_addr  <= host.cmd_base;
                  words_left <= (host.cmd_words == 5'd0) ? 6'd32 : {1'b0, host.cmd_words};
                  pending    <= 1'b0;
               end
            end
            HS_LOAD: begin
               if (pack_last) begin
                  pending <= 1'b1;
               end else if (host_wr) begin
                  pending    <= 1'b0;
                  host_addr  <= host_addr + 8'd1;
                  words_left <= words_left - 6'd1;
               end
            end
            HS_CAP: begin
               out_word <= r_data;
               out_lane <= '0;
            end
            HS_OUT: begin
               if (host.out_ready) begin
                  out_lane <= out_lane + 3'd1;
                  if (last_lane) begin
                     host_addr  <= host_addr + 8'd1;
                     words_left <= words_left - 6'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ntt_coef_ram.sv
module tb_ntt_coef_ram;
   import ntt_pkg::*;

   logic  clk   = 1'b0;
   logic  rst_n = 1'b1;
   addr_t r_data_addr;
   word_t r_data;
   logic  w_data_en;
   addr_t w_data_addr;
   word_t w_data;

   int    checks = 0;
   int    errors = 0;
   word_t model [256];

   ntt_coef_ram_if hif ();

   ntt_coef_ram #(.Q(3329), .DEPTH(256)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .r_data_addr (r_data_addr),
      .r_data      (r_data),
      .w_data_en   (w_data_en),
      .w_data_addr (w_data_addr),
      .w_data      (w_data),
      .host        (hif)
   );

   always #5 clk = ~clk;

   // Background pattern: lane k of word a holds a*16+k.
   function automatic word_t pat(input int a);
      word_t w;
      for (int k = 0; k < 8; k++) w[k*12 +: 12] = coef_t'(a*16 + k);
      return w;
   endfunction

   task automatic core_write(input addr_t a, input word_t d);
      w_data_en   = 1'b1;
      w_data_addr = a;
      w_data      = d;
      @(negedge clk);
      w_data_en   = 1'b0;
      model[a]    = d;
   endtask

   // Streams the eight raw lanes of 'raw' into the LOAD port; 'taken' counts
   // accepted coefficients within a fixed cycle budget.
   task automatic feed_word(input word_t raw, output int taken);
      logic hs;
      int   cyc;
      taken = 0;
      cyc   = 0;
      while (taken < 8 && cyc < 100) begin
         hif.in_valid = 1'b1;
         hif.in_coef  = raw[taken*12 +: 12];
         hs           = hif.in_ready;
         @(negedge clk);
         cyc++;
         if (hs) taken++;
      end
      hif.in_valid = 1'b0;
   endtask

   task automatic issue_cmd(input logic op, input addr_t base, input logic [4:0] words);
      hif.cmd_valid = 1'b1;
      hif.cmd_op    = op;
      hif.cmd_base  = base;
      hif.cmd_words = words;
      @(negedge clk);
      hif.cmd_valid = 1'b0;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (r_data !== '0) begin errors++; $display("FAIL reset_r_data actual=%h required=0", r_data); end
      checks++; if (hif.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready actual=%b required=1", hif.cmd_ready); end
      checks++; if (hif.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready actual=%b required=0", hif.in_ready); end
      checks++; if (hif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid actual=%b required=0", hif.out_valid); end
      checks++; if (hif.out_coef !== '0) begin errors++; $display("FAIL reset_out_coef actual=%0d required=0", hif.out_coef); end
      checks++; if (hif.host_done !== 1'b0) begin errors++; $display("FAIL reset_host_done actual=%b required=0", hif.host_done); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_core_stream;
      word_t w0;
      w0 = {12'd193, 12'd192, 12'd65, 12'd64, 12'd129, 12'd128, 12'd1, 12'd0};
      r_data_addr = 8'd1;
      core_write(8'd0, w0);
      r_data_addr = 8'd0;
      @(negedge clk);
      checks++; if (r_data !== w0) begin errors++; $display("FAIL stream_w0 actual=%h required=%h", r_data, w0); end
      for (int a = 0; a < 256; a++) core_write(addr_t'(a), pat(a));
      for (int a = 0; a < 32; a++) begin
         r_data_addr = addr_t'(a);
         @(negedge clk);
         checks++;
         if (r_data !== model[a]) begin
            errors++; $display("FAIL stream_b2b addr=%0d actual=%h required=%h", a, r_data, model[a]);
         end
      end
   endtask

   task automatic test_bypass;
      word_t nv;
      nv          = 96'h123456789ABCDEF0123450AB;
      r_data_addr = 8'd5;
      w_data_en   = 1'b1;
      w_data_addr = 8'd5;
      w_data      = nv;
      @(negedge clk);
      w_data_en = 1'b0;
      model[5]  = nv;
      checks++; if (r_data !== nv) begin errors++; $display("FAIL bypass actual=%h required=%h", r_data, nv); end
   endtask

   task automatic test_load_reduce;
      word_t raw, ew;
      int    taken, pulses;
      raw = {12'd13, 12'd12, 12'd4095, 12'd3330, 12'd3329, 12'd3328, 12'd1, 12'd0};
      ew  = {12'd13, 12'd12, 12'd766,  12'd1,    12'd0,    12'd3328, 12'd1, 12'd0};
      issue_cmd(1'b0, 8'd0, 5'd1);
      checks++; if (hif.in_ready !== 1'b1) begin errors++; $display("FAIL load_in_ready_rise actual=%b required=1", hif.in_ready); end
      checks++; if (hif.cmd_ready !== 1'b0) begin errors++; $display("FAIL load_cmd_ready_busy actual=%b required=0", hif.cmd_ready); end
      feed_word(raw, taken);
      checks++; if (taken != 8) begin errors++; $display("FAIL load_accept actual=%0d required=8", taken); end
      checks++; if (hif.in_ready !== 1'b0) begin errors++; $display("FAIL load_pending_ready actual=%b required=0", hif.in_ready); end
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         if (hif.host_done === 1'b1) pulses++;
         @(negedge clk);
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL load_done_pulses actual=%0d required=1", pulses); end
      model[0]    = ew;
      r_data_addr = 8'd0;
      @(negedge clk);
      checks++; if (r_data !== ew) begin errors++; $display("FAIL load_word actual=%h required=%h", r_data, ew); end
   endtask

   task automatic test_unload_backpressure;
      int    recv, cyc;
      logic  tgl, done;
      addr_t wa;
      coef_t exp_c;
      hif.out_ready = 1'b0;
      r_data_addr   = 8'd250;
      issue_cmd(1'b1, 8'd250, 5'd0);
      recv = 0; cyc = 0; tgl = 1'b1; done = 1'b0;
      while (!done && cyc < 4000) begin
         if (hif.host_done === 1'b1) begin
            done = 1'b1;
         end else begin
            hif.out_ready = tgl;
            tgl = !tgl;
            if (hif.out_valid === 1'b1 && hif.out_ready) begin
               checks++;
               if (recv >= 256) begin
                  errors++; $display("FAIL unload_extra_coef index=%0d", recv);
               end else begin
                  wa    = addr_t'(250 + recv / 8);
                  exp_c = model[wa][(recv % 8)*12 +: 12];
                  if (hif.out_coef !== exp_c) begin
                     errors++; $display("FAIL unload_coef index=%0d actual=%0d required=%0d", recv, hif.out_coef, exp_c);
                  end
               end
               recv++;
            end
            r_data_addr = addr_t'(250 + recv / 8);
            @(negedge clk);
            cyc++;
         end
      end
      hif.out_ready = 1'b0;
      checks++; if (!done) begin errors++; $display("FAIL unload_timeout actual=no_done required=done"); end
      checks++; if (recv != 256) begin errors++; $display("FAIL unload_count actual=%0d required=256", recv); end
      @(negedge clk);
      checks++; if (hif.host_done !== 1'b0) begin errors++; $display("FAIL unload_done_width actual=%b required=0", hif.host_done); end
      checks++; if (hif.cmd_ready !== 1'b1) begin errors++; $display("FAIL unload_idle actual=%b required=1", hif.cmd_ready); end
   endtask

   task automatic test_contention;
      word_t raw, ew, xv, old;
      int    taken, pulses, bad_ready, bad_data;
      raw = {12'd3329, 12'd3328, 12'd500, 12'd400, 12'd300, 12'd200, 12'd100, 12'd3400};
      ew  = {12'd0,    12'd3328, 12'd500, 12'd400, 12'd300, 12'd200, 12'd100, 12'd71};
      xv  = 96'hC0FFEE_123456_789ABC_DEF012;
      old = model[40];
      w_data_en   = 1'b1;
      w_data_addr = 8'd200;
      w_data      = xv;
      model[200]  = xv;
      r_data_addr = 8'd40;
      issue_cmd(1'b0, 8'd40, 5'd1);
      feed_word(raw, taken);
      checks++; if (taken != 8) begin errors++; $display("FAIL contend_accept actual=%0d required=8", taken); end
      bad_ready = 0; bad_data = 0;
      for (int c = 0; c < 10; c++) begin
         if (hif.in_ready !== 1'b0 || hif.host_done !== 1'b0) bad_ready++;
         if (r_data !== old) bad_data++;
         @(negedge clk);
      end
      checks++; if (bad_ready != 0) begin errors++; $display("FAIL contend_hold actual=%0d_bad_cycles required=0", bad_ready); end
      checks++; if (bad_data != 0) begin errors++; $display("FAIL contend_no_host_write actual=%0d_bad_cycles required=0", bad_data); end
      w_data_en = 1'b0;
      pulses = 0;
      for (int c = 0; c < 6; c++) begin
         if (hif.host_done === 1'b1) pulses++;
         @(negedge clk);
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL contend_done_pulses actual=%0d required=1", pulses); end
      checks++; if (r_data !== ew) begin errors++; $display("FAIL contend_word actual=%h required=%h", r_data, ew); end
      model[40]   = ew;
      r_data_addr = 8'd200;
      @(negedge clk);
      checks++; if (r_data !== xv) begin errors++; $display("FAIL contend_core_word actual=%h required=%h", r_data, xv); end
   endtask

   task automatic test_reset_mid_unload;
      int    recv, cyc;
      coef_t exp_c;
      hif.out_ready = 1'b1;
      r_data_addr   = 8'd0;
      issue_cmd(1'b1, 8'd0, 5'd2);
      recv = 0; cyc = 0;
      while (recv < 3 && cyc < 50) begin
         if (hif.out_valid === 1'b1) recv++;
         r_data_addr = addr_t'(recv / 8);
         @(negedge clk);
         cyc++;
      end
      checks++; if (hif.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_streaming actual=%b required=1", hif.out_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (hif.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid actual=%b required=0", hif.out_valid); end
      checks++; if (hif.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_cmd_ready actual=%b required=1", hif.cmd_ready); end
      checks++; if (hif.out_coef !== '0) begin errors++; $display("FAIL midrst_out_coef actual=%0d required=0", hif.out_coef); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      r_data_addr = 8'd10;
      issue_cmd(1'b1, 8'd10, 5'd1);
      checks++; if (hif.out_valid !== 1'b0) begin errors++; $display("FAIL newcmd_lat1 actual=%b required=0", hif.out_valid); end
      @(negedge clk);
      checks++; if (hif.out_valid !== 1'b0) begin errors++; $display("FAIL newcmd_lat2 actual=%b required=0", hif.out_valid); end
      @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         exp_c = model[10][k*12 +: 12];
         checks++;
         if (hif.out_valid !== 1'b1 || hif.out_coef !== exp_c) begin
            errors++; $display("FAIL newcmd_lane%0d actual=%b/%0d required=1/%0d", k, hif.out_valid, hif.out_coef, exp_c);
         end
         @(negedge clk);
      end
      checks++; if (hif.host_done !== 1'b1) begin errors++; $display("FAIL newcmd_done actual=%b required=1", hif.host_done); end
      hif.out_ready = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      r_data_addr   = '0;
      w_data_en     = 1'b0;
      w_data_addr   = '0;
      w_data        = '0;
      hif.cmd_valid = 1'b0;
      hif.cmd_op    = 1'b0;
      hif.cmd_base  = '0;
      hif.cmd_words = '0;
      hif.in_valid  = 1'b0;
      hif.in_coef   = '0;
      hif.out_ready = 1'b0;
      test_reset();
      test_core_stream();
      test_bypass();
      test_load_reduce();
      test_unload_backpressure();
      test_contention();
      test_reset_mid_unload();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
